// File: rtl/mpsoc_dbg_jsp_wb_biu_sync.sv
// Wishbone slave for the JTAG serial port: two byte FIFOs between the debug host
// and a 16550-style register map, with interrupt identification and RX timeout.
module mpsoc_dbg_jsp_wb_biu_sync #(
  parameter  int DEPTH   = 16,
  parameter  int TIMEOUT = 1024,
  localparam int CW      = $clog2(DEPTH) + 1
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic [7:0]    dbg_wr_data_i,
  input  logic          dbg_wr_valid_i,
  output logic          dbg_wr_ready_o,
  output logic [7:0]    dbg_rd_data_o,
  output logic          dbg_rd_valid_o,
  input  logic          dbg_rd_ready_i,
  output logic [CW-1:0] dbg_bytes_avail_o,
  output logic [CW-1:0] dbg_bytes_free_o,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic          wb_we_i,
  input  logic [2:0]    wb_adr_i,
  input  logic [7:0]    wb_dat_i,
  output logic [7:0]    wb_dat_o,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic          int_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);
  localparam logic [TW-1:0] TO_LAST_C = TW'(TIMEOUT - 1);

  logic [7:0]    rx_mem [DEPTH];
  logic [7:0]    tx_mem [DEPTH];
  logic [AW-1:0] rx_rd_ptr_reg, rx_wr_ptr_reg, tx_rd_ptr_reg, tx_wr_ptr_reg;
  logic [CW-1:0] rx_cnt_reg, tx_cnt_reg, rx_cnt_next, tx_cnt_next;
  logic [3:0]    ier_reg;
  logic [7:0]    lcr_reg, dll_reg, dlm_reg, scr_reg;
  logic [1:0]    trig_sel_reg;
  logic          oe_reg, cto_reg, thre_arm_reg, ack_reg;
  logic [TW-1:0] to_cnt_reg;

  logic [CW-1:0] rx_trig;
  logic [7:0]    iir, lsr, rx_head;
  logic          dlab, wb_acc, wb_wr, wb_rd;
  logic          rbr_rd, thr_wr, dll_wr, ier_wr, dlm_wr, iir_rd, fcr_wr, lcr_wr, lsr_rd, scr_wr;
  logic          rx_full, rx_empty, tx_full, tx_empty;
  logic          rx_push, rx_pop, rx_clr, tx_push, tx_pop, tx_clr, tx_ovf;
  logic          rx_activity, to_run, arm_set, arm_clr;

  // Register side effects happen only in the ack cycle, while the master still holds the strobe.
  assign dlab   = lcr_reg[7];
  assign wb_acc = wb_cyc_i & wb_stb_i & ack_reg;
  assign wb_wr  = wb_acc & wb_we_i;
  assign wb_rd  = wb_acc & ~wb_we_i;

  assign rbr_rd = wb_rd & (wb_adr_i == 3'd0) & ~dlab;
  assign thr_wr = wb_wr & (wb_adr_i == 3'd0) & ~dlab;
  assign dll_wr = wb_wr & (wb_adr_i == 3'd0) & dlab;
  assign ier_wr = wb_wr & (wb_adr_i == 3'd1) & ~dlab;
  assign dlm_wr = wb_wr & (wb_adr_i == 3'd1) & dlab;
  assign iir_rd = wb_rd & (wb_adr_i == 3'd2);
  assign fcr_wr = wb_wr & (wb_adr_i == 3'd2);
  assign lcr_wr = wb_wr & (wb_adr_i == 3'd3);
  assign lsr_rd = wb_rd & (wb_adr_i == 3'd5);
  assign scr_wr = wb_wr & (wb_adr_i == 3'd7);

  assign rx_full  = (rx_cnt_reg == DEPTH_C);
  assign rx_empty = (rx_cnt_reg == '0);
  assign tx_full  = (tx_cnt_reg == DEPTH_C);
  assign tx_empty = (tx_cnt_reg == '0);

  assign rx_clr  = fcr_wr & wb_dat_i[1];
  assign rx_push = dbg_wr_valid_i & ~rx_full;
  assign rx_pop  = rbr_rd & ~rx_empty;
  assign tx_clr  = fcr_wr & wb_dat_i[2];
  assign tx_push = thr_wr & ~tx_full;
  assign tx_pop  = ~tx_empty & dbg_rd_ready_i;
  assign tx_ovf  = thr_wr & tx_full;

  always_comb begin
    rx_cnt_next = rx_cnt_reg;
    if (rx_clr)
      rx_cnt_next = '0;
    else if (rx_push & ~rx_pop)
      rx_cnt_next = rx_cnt_reg + 1'b1;
    else if (~rx_push & rx_pop)
      rx_cnt_next = rx_cnt_reg - 1'b1;
  end

  always_comb begin
    tx_cnt_next = tx_cnt_reg;
    if (tx_clr)
      tx_cnt_next = '0;
    else if (tx_push & ~tx_pop)
      tx_cnt_next = tx_cnt_reg + 1'b1;
    else if (~tx_push & tx_pop)
      tx_cnt_next = tx_cnt_reg - 1'b1;
  end

  always_comb begin
    case (trig_sel_reg)
      2'b00:   rx_trig = CW'(1);
      2'b01:   rx_trig = CW'(DEPTH / 4);
      2'b10:   rx_trig = CW'(DEPTH / 2);
      default: rx_trig = CW'(DEPTH - 2);
    endcase
  end

  // Timeout only runs while a partial batch below the trigger level sits idle.
  assign rx_activity = rx_push | rx_pop | rx_clr;
  assign to_run      = ~rx_empty & (rx_cnt_reg < rx_trig) & ~rx_activity;

  always_comb begin
    if (oe_reg & ier_reg[2])
      iir = 8'hC6;
    else if ((rx_cnt_reg >= rx_trig) & ier_reg[0])
      iir = 8'hC4;
    else if (cto_reg & ier_reg[0])
      iir = 8'hCC;
    else if (thre_arm_reg & ier_reg[1])
      iir = 8'hC2;
    else
      iir = 8'hC1;
  end

  assign arm_set = ((tx_pop | tx_clr) & (tx_cnt_next == '0)) |
                   (ier_wr & wb_dat_i[1] & ~ier_reg[1] & tx_empty);
  assign arm_clr = thr_wr | (iir_rd & (iir == 8'hC2));

  assign lsr     = {1'b0, tx_empty, ~tx_full, 3'b000, oe_reg, ~rx_empty};
  assign rx_head = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr_reg];

  always_comb begin
    case (wb_adr_i)
      3'd0:    wb_dat_o = dlab ? dll_reg : rx_head;
      3'd1:    wb_dat_o = dlab ? dlm_reg : {4'h0, ier_reg};
      3'd2:    wb_dat_o = iir;
      3'd3:    wb_dat_o = lcr_reg;
      3'd4:    wb_dat_o = 8'h00;
      3'd5:    wb_dat_o = lsr;
      3'd6:    wb_dat_o = 8'hB0;
      default: wb_dat_o = scr_reg;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (rx_push)
      rx_mem[rx_wr_ptr_reg] <= dbg_wr_data_i;
    if (tx_push)
      tx_mem[tx_wr_ptr_reg] <= wb_dat_i;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rx_rd_ptr_reg <= '0;
      rx_wr_ptr_reg <= '0;
      tx_rd_ptr_reg <= '0;
      tx_wr_ptr_reg <= '0;
      rx_cnt_reg    <= '0;
      tx_cnt_reg    <= '0;
      ier_reg       <= '0;
      lcr_reg       <= '0;
      dll_reg       <= '0;
      dlm_reg       <= '0;
      scr_reg       <= '0;
      trig_sel_reg  <= 2'b00;
      oe_reg        <= 1'b0;
      cto_reg       <= 1'b0;
      thre_arm_reg  <= 1'b0;
      to_cnt_reg    <= '0;
      ack_reg       <= 1'b0;
    end else begin
      ack_reg    <= wb_cyc_i & wb_stb_i & ~ack_reg;
      rx_cnt_reg <= rx_cnt_next;
      tx_cnt_reg <= tx_cnt_next;

      if (rx_clr) begin
        rx_rd_ptr_reg <= '0;
        rx_wr_ptr_reg <= '0;
      end else begin
        if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + 1'b1;
        if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + 1'b1;
      end

      if (tx_clr) begin
        tx_rd_ptr_reg <= '0;
        tx_wr_ptr_reg <= '0;
      end else begin
        if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + 1'b1;
        if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + 1'b1;
      end

      if (ier_wr) ier_reg <= wb_dat_i[3:0];
      if (lcr_wr) lcr_reg <= wb_dat_i;
      if (dll_wr) dll_reg <= wb_dat_i;
      if (dlm_wr) dlm_reg <= wb_dat_i;
      if (scr_wr) scr_reg <= wb_dat_i;
      if (fcr_wr) trig_sel_reg <= wb_dat_i[7:6];

      if (tx_ovf)
        oe_reg <= 1'b1;
      else if (lsr_rd)
        oe_reg <= 1'b0;

      if (rx_activity)
        to_cnt_reg <= '0;
      else if (to_run && (to_cnt_reg != TIMEOUT_C))
        to_cnt_reg <= to_cnt_reg + 1'b1;

      if (rbr_rd | rx_push | rx_clr)
        cto_reg <= 1'b0;
      else if (to_run && (to_cnt_reg == TO_LAST_C))
        cto_reg <= 1'b1;

      if (arm_set)
        thre_arm_reg <= 1'b1;
      else if (arm_clr)
        thre_arm_reg <= 1'b0;
    end
  end

  assign dbg_wr_ready_o    = ~rx_full;
  assign dbg_rd_valid_o    = ~tx_empty;
  assign dbg_rd_data_o     = tx_empty ? 8'h00 : tx_mem[tx_rd_ptr_reg];
  assign dbg_bytes_avail_o = tx_cnt_reg;
  assign dbg_bytes_free_o  = DEPTH_C - rx_cnt_reg;
  assign wb_ack_o          = ack_reg;
  assign wb_err_o          = 1'b0;
  assign int_o             = (iir != 8'hC1);

endmodule

// File: tb/tb_mpsoc_dbg_jsp_wb_biu_sync.sv
// Directed bench for the JTAG serial port Wishbone BIU; expected bytes are queued
// when stimulus is driven and popped when the DUT presents them.
`timescale 1ns/1ps
module tb_mpsoc_dbg_jsp_wb_biu_sync;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 64;
  localparam int CW      = $clog2(DEPTH) + 1;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i = 1'b1;
  logic [7:0]    dbg_wr_data_i = '0;
  logic          dbg_wr_valid_i = 1'b0;
  logic          dbg_wr_ready_o;
  logic [7:0]    dbg_rd_data_o;
  logic          dbg_rd_valid_o;
  logic          dbg_rd_ready_i = 1'b0;
  logic [CW-1:0] dbg_bytes_avail_o;
  logic [CW-1:0] dbg_bytes_free_o;
  logic          wb_cyc_i = 1'b0;
  logic          wb_stb_i = 1'b0;
  logic          wb_we_i = 1'b0;
  logic [2:0]    wb_adr_i = '0;
  logic [7:0]    wb_dat_i = '0;
  logic [7:0]    wb_dat_o;
  logic          wb_ack_o;
  logic          wb_err_o;
  logic          int_o;

  int checks = 0;
  int failures = 0;
  logic [7:0] wb_exp_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic       oe_m = 1'b0;

  always #5 wb_clk_i = ~wb_clk_i;

  mpsoc_dbg_jsp_wb_biu_sync #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .dbg_wr_data_i(dbg_wr_data_i), .dbg_wr_valid_i(dbg_wr_valid_i), .dbg_wr_ready_o(dbg_wr_ready_o),
    .dbg_rd_data_o(dbg_rd_data_o), .dbg_rd_valid_o(dbg_rd_valid_o), .dbg_rd_ready_i(dbg_rd_ready_i),
    .dbg_bytes_avail_o(dbg_bytes_avail_o), .dbg_bytes_free_o(dbg_bytes_free_o),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i),
    .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .int_o(int_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] lsr_exp();
    return {1'b0, tx_q.size() == 0, tx_q.size() < DEPTH, 3'b000, oe_m, rx_q.size() != 0};
  endfunction

  task automatic wb_xfer(input logic we, input logic [2:0] adr, input logic [7:0] dat,
                         input logic [7:0] exp_rd, input string tag);
    int n;
    logic [7:0] e;
    if (!we) wb_exp_q.push_back(exp_rd);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat;
    n = 0;
    do begin
      @(posedge wb_clk_i); #1; n++;
    end while (!wb_ack_o && n < 8);
    chk({tag, " ack_latency"}, n, 32'd1);
    if (!we) begin
      e = wb_exp_q.pop_front();
      chk(tag, 32'(wb_dat_o), 32'(e));
      $display("wb rd adr=%0d data=0x%02h exp=0x%02h (%s)", adr, wb_dat_o, e, tag);
    end else begin
      $display("wb wr adr=%0d data=0x%02h (%s)", adr, dat, tag);
    end
    @(posedge wb_clk_i); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wb_write(input logic [2:0] adr, input logic [7:0] dat, input string tag);
    wb_xfer(1'b1, adr, dat, 8'h00, tag);
  endtask

  task automatic wb_read(input logic [2:0] adr, input logic [7:0] exp, input string tag);
    wb_xfer(1'b0, adr, 8'h00, exp, tag);
  endtask

  task automatic lsr_read(input string tag);
    wb_read(3'd5, lsr_exp(), tag);
    oe_m = 1'b0;
  endtask

  task automatic rbr_read(input string tag);
    logic [7:0] e;
    e = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
    wb_read(3'd0, e, tag);
  endtask

  task automatic thr_write(input logic [7:0] b);
    if (tx_q.size() < DEPTH) tx_q.push_back(b);
    else oe_m = 1'b1;
    wb_write(3'd0, b, "thr");
  endtask

  task automatic host_push(input logic [7:0] b);
    int n;
    n = 0;
    dbg_wr_valid_i = 1'b1; dbg_wr_data_i = b;
    while (!dbg_wr_ready_o && n < 64) begin
      @(posedge wb_clk_i); #1; n++;
    end
    if (rx_q.size() < DEPTH) rx_q.push_back(b);
    @(posedge wb_clk_i); #1;
    dbg_wr_valid_i = 1'b0;
    $display("host push 0x%02h", b);
  endtask

  task automatic host_pop(input string tag);
    logic [7:0] e;
    e = (tx_q.size() != 0) ? tx_q.pop_front() : 8'h00;
    chk({tag, " valid"}, 32'(dbg_rd_valid_o), 32'd1);
    chk(tag, 32'(dbg_rd_data_o), 32'(e));
    $display("host pop 0x%02h exp=0x%02h (%s)", dbg_rd_data_o, e, tag);
    dbg_rd_ready_i = 1'b1;
    @(posedge wb_clk_i); #1;
    dbg_rd_ready_i = 1'b0;
  endtask

  initial begin
    int early;
    int acks;
    repeat (3) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;

    // Reset state
    chk("rst ack", 32'(wb_ack_o), 32'd0);
    chk("rst err", 32'(wb_err_o), 32'd0);
    chk("rst int", 32'(int_o), 32'd0);
    chk("rst wr_ready", 32'(dbg_wr_ready_o), 32'd1);
    chk("rst rd_valid", 32'(dbg_rd_valid_o), 32'd0);
    chk("rst rd_data", 32'(dbg_rd_data_o), 32'd0);
    chk("rst avail", 32'(dbg_bytes_avail_o), 32'd0);
    chk("rst free", 32'(dbg_bytes_free_o), 32'(DEPTH));
    wb_read(3'd2, 8'hC1, "rst iir");
    lsr_read("rst lsr");

    // RX trigger interrupt and in-order reads
    host_push(8'h41); host_push(8'h42); host_push(8'h43);
    chk("rx free3", 32'(dbg_bytes_free_o), 32'(DEPTH - 3));
    wb_write(3'd1, 8'h01, "ier");
    wb_write(3'd2, 8'h00, "fcr");
    chk("rx int", 32'(int_o), 32'd1);
    wb_read(3'd2, 8'hC4, "iir rx");
    rbr_read("rbr0"); rbr_read("rbr1"); rbr_read("rbr2");
    lsr_read("lsr rx empty");
    chk("rx int clr", 32'(int_o), 32'd0);

    // TX overflow with stalled host
    for (int i = 0; i < DEPTH + 1; i++) thr_write(8'(i));
    chk("tx avail full", 32'(dbg_bytes_avail_o), 32'(DEPTH));
    chk("tx head", 32'(dbg_rd_data_o), 32'h00);
    lsr_read("lsr oe");
    lsr_read("lsr oe clr");
    for (int i = 0; i < DEPTH; i++) host_pop($sformatf("drain%0d", i));
    chk("tx avail empty", 32'(dbg_bytes_avail_o), 32'd0);
    lsr_read("lsr tx empty");

    // THRE interrupt
    wb_write(3'd1, 8'h02, "ier thre");
    chk("thre armed", 32'(int_o), 32'd1);
    thr_write(8'h5A);
    chk("thre cleared by thr", 32'(int_o), 32'd0);
    host_pop("tx 5a");
    chk("thre int", 32'(int_o), 32'd1);
    wb_read(3'd2, 8'hC2, "iir thre");
    wb_read(3'd2, 8'hC1, "iir thre clr");
    chk("thre int clr", 32'(int_o), 32'd0);

    // Character timeout with T=8
    wb_write(3'd2, 8'h80, "fcr t8");
    wb_write(3'd1, 8'h01, "ier rx");
    host_push(8'h11); host_push(8'h22);
    early = 0;
    for (int i = 1; i < TIMEOUT; i++) begin
      @(posedge wb_clk_i); #1;
      if (int_o) early++;
    end
    chk("cto quiet", early, 32'd0);
    @(posedge wb_clk_i); #1;
    chk("cto int", 32'(int_o), 32'd1);
    wb_read(3'd2, 8'hCC, "iir cto");
    rbr_read("rbr cto");
    chk("cto clr", 32'(int_o), 32'd0);
    rbr_read("rbr cto2");

    // RX full, then clear against a concurrent host byte
    wb_write(3'd1, 8'h00, "ier off");
    for (int i = 0; i < DEPTH; i++) host_push(8'(8'hA0 + i));
    chk("rx free0", 32'(dbg_bytes_free_o), 32'd0);
    chk("rx not ready", 32'(dbg_wr_ready_o), 32'd0);
    dbg_wr_valid_i = 1'b1; dbg_wr_data_i = 8'hEE;
    wb_write(3'd2, 8'h02, "fcr rxclr full");
    dbg_wr_valid_i = 1'b0;
    rx_q.delete();
    chk("rxclr free", 32'(dbg_bytes_free_o), 32'(DEPTH));
    lsr_read("lsr after rxclr");
    rbr_read("rbr empty");
    chk("rbr empty no pop", 32'(dbg_bytes_free_o), 32'(DEPTH));
    host_push(8'hB1); host_push(8'hB2); host_push(8'hB3);
    dbg_wr_valid_i = 1'b1; dbg_wr_data_i = 8'hEE;
    wb_write(3'd2, 8'h02, "fcr rxclr push");
    dbg_wr_valid_i = 1'b0;
    rx_q.delete();
    chk("clr beats push", 32'(dbg_bytes_free_o), 32'(DEPTH));

    // TX clear
    thr_write(8'h01); thr_write(8'h02);
    chk("tx avail2", 32'(dbg_bytes_avail_o), 32'd2);
    wb_write(3'd2, 8'h04, "fcr txclr");
    tx_q.delete();
    chk("txclr avail", 32'(dbg_bytes_avail_o), 32'd0);
    chk("txclr data", 32'(dbg_rd_data_o), 32'd0);

    // Plain registers and DLAB
    wb_write(3'd7, 8'hA5, "scr");
    wb_read(3'd7, 8'hA5, "scr rd");
    wb_write(3'd3, 8'h80, "lcr dlab");
    wb_write(3'd0, 8'h12, "dll");
    wb_write(3'd1, 8'h34, "dlm");
    wb_read(3'd0, 8'h12, "dll rd");
    wb_read(3'd1, 8'h34, "dlm rd");
    wb_read(3'd3, 8'h80, "lcr rd");
    chk("dll no push", 32'(dbg_bytes_avail_o), 32'd0);
    wb_write(3'd3, 8'h00, "lcr");
    wb_read(3'd1, 8'h00, "ier rd");
    wb_write(3'd4, 8'hFF, "mcr");
    wb_read(3'd4, 8'h00, "mcr rd");
    wb_read(3'd6, 8'hB0, "msr rd");

    // Held strobe acks every second cycle
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 3'd7;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge wb_clk_i); #1;
      if (wb_ack_o) acks++;
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    chk("held stb acks", acks, 32'd4);
    $display("held strobe acks=%0d", acks);
    @(posedge wb_clk_i); #1;

    // Reset mid-transfer
    thr_write(8'h77);
    host_push(8'h66);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_adr_i = 3'd7; wb_rst_i = 1'b1;
    @(posedge wb_clk_i); #1;
    chk("rst mid ack", 32'(wb_ack_o), 32'd0);
    wb_rst_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(posedge wb_clk_i); #1;
    chk("rst mid ack2", 32'(wb_ack_o), 32'd0);
    tx_q.delete(); rx_q.delete(); oe_m = 1'b0;
    chk("rst mid avail", 32'(dbg_bytes_avail_o), 32'd0);
    chk("rst mid free", 32'(dbg_bytes_free_o), 32'(DEPTH));
    chk("rst mid valid", 32'(dbg_rd_valid_o), 32'd0);
    lsr_read("rst mid lsr");
    wb_read(3'd7, 8'h00, "rst mid scr");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
